// File: rtl/bin_to_bcd_if.sv
// Request/result bundle for the binary-to-BCD converter.
// master drives the request. slave is the converter, which returns status and digits.
interface bin_to_bcd_if #(
  parameter int BIN_W = 20
) ();
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [3:0]       hundreds;
  logic [3:0]       thousands;
  logic [3:0]       ten_thousands;
  logic [3:0]       hun_thousands;

  modport master (
    output start, bin,
    input  busy, done, overflow,
    input  ones, tens, hundreds, thousands, ten_thousands, hun_thousands
  );

  modport slave (
    input  start, bin,
    output busy, done, overflow,
    output ones, tens, hundreds, thousands, ten_thousands, hun_thousands
  );
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter. It takes one bit per clock.
// An accepted start is followed by BIN_W shift steps and then one DONE cycle that
// publishes the result. Values above 999_999 saturate the digits to all 9s and set overflow.
module bin_to_bcd #(
  parameter int BIN_W = 20
) (
  input  logic       clk,
  input  logic       KEY2,
  bin_to_bcd_if.slave bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int WK_W  = 24;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   sreg;
  logic [WK_W-1:0]    work;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_cap;
  logic [WK_W-1:0]    digits_q;
  logic               ovf_q;
  logic               done_q;

  logic               capture, step, load, busy;
  logic [WK_W-1:0]    corr;
  logic [WK_W+BIN_W-1:0] shifted;
  logic               last_step;
  logic               bin_big;

  assign last_step = (cnt == CNT_W'(BIN_W - 1));
  // Zero-extend so the compare is legal at every supported width. Below 20 bits it can never be true.
  assign bin_big   = ({{(32-BIN_W){1'b0}}, bus.bin} > 32'd999_999);

  // Double-dabble correction: add 3 to every nibble >= 5, then shift {work, sreg} left by one bit.
  always_comb begin
    corr = work;
    for (int i = 0; i < WK_W/4; i++) begin
      if (work[i*4 +: 4] >= 4'd5) corr[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
    end
    shifted = {corr[WK_W-2:0], sreg, 1'b0};
  end

  // State register.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded controls. start is only honoured in IDLE, so requests while busy are dropped.
  always_comb begin
    capture = (state == IDLE) && bus.start;
    step    = (state == SHIFT);
    load    = (state == DONE);
    busy    = (state != IDLE);
  end

  // Working datapath: capture, step, and latch the overflow flag from the captured value.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      sreg    <= '0;
      work    <= '0;
      cnt     <= '0;
      ovf_cap <= 1'b0;
    end else if (capture) begin
      sreg    <= bus.bin;
      work    <= '0;
      cnt     <= '0;
      ovf_cap <= bin_big;
    end else if (step) begin
      {work, sreg} <= shifted;
      cnt          <= cnt + 1'b1;
    end
  end

  // Result registers. They change only on the DONE edge, so intermediate values never reach the outputs.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      digits_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= load;
      if (load) begin
        ovf_q    <= ovf_cap;
        digits_q <= ovf_cap ? 24'h999999 : work;
      end
    end
  end

  assign bus.busy          = busy;
  assign bus.done          = done_q;
  assign bus.overflow      = ovf_q;
  assign bus.ones          = digits_q[3:0];
  assign bus.tens          = digits_q[7:4];
  assign bus.hundreds      = digits_q[11:8];
  assign bus.thousands     = digits_q[15:12];
  assign bus.ten_thousands = digits_q[19:16];
  assign bus.hun_thousands = digits_q[23:20];
endmodule
